// File: rtl/adder_64_pkg.sv
// Shared widths and the stage-to-stage bus type for the pipelined 64-bit adder.
package adder_64_pkg;

    localparam int LEN_DATA   = 64;
    localparam int NUM_STAGES = 4;
    localparam int SLICE_W    = LEN_DATA / NUM_STAGES;

    // Everything one pipeline stage hands to the next: the stage valid bit,
    // the carry out of the slice just added, the operands (upper slices are
    // still pending) and the partially assembled sum (lower slices are done).
    typedef struct packed {
        logic                valid;
        logic                carry;
        logic [LEN_DATA-1:0] a;
        logic [LEN_DATA-1:0] b;
        logic [LEN_DATA-1:0] sum;
    } stage_t;

endpackage : adder_64_pkg

// File: rtl/adder_64_stage.sv
// One pipeline stage: adds one SLICE-wide slice of a and b with the incoming
// carry, merges the result into the partial sum and registers the lot.
module adder_64_stage
    import adder_64_pkg::*;
#(
    parameter int SLICE     = SLICE_W,
    parameter int STAGE_IDX = 0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  stage_t stage_in,
    output stage_t stage_out
);

    localparam int LO = STAGE_IDX * SLICE;

    logic [SLICE:0] slice_sum;
    stage_t         stage_next;

    assign slice_sum = {1'b0, stage_in.a[LO +: SLICE]}
                     + {1'b0, stage_in.b[LO +: SLICE]}
                     + {{SLICE{1'b0}}, stage_in.carry};

    // Replace this stage's slice of the partial sum and produce the new carry.
    always_comb begin
        stage_next                   = stage_in;
        stage_next.sum[LO +: SLICE]  = slice_sum[SLICE-1:0];
        stage_next.carry             = slice_sum[SLICE];
    end

    // Valid bit advances every enabled cycle; data only loads for a real
    // operand, so the last stage's sum holds its previous result across bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_out <= '0;
        end else if (en) begin
            stage_out.valid <= stage_next.valid;
            if (stage_next.valid) begin
                stage_out.carry <= stage_next.carry;
                stage_out.a     <= stage_next.a;
                stage_out.b     <= stage_next.b;
                stage_out.sum   <= stage_next.sum;
            end
        end
    end

endmodule : adder_64_stage

// File: rtl/adder_64.sv
// Pipelined 64-bit adder: NUM_STAGES slice stages with a rippling carry;
// the last stage register is the output register (sum / rdy).
module adder_64
    import adder_64_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                valid,
    input  logic [LEN_DATA-1:0] a,
    input  logic [LEN_DATA-1:0] b,
    output logic [LEN_DATA-1:0] sum,
    output logic                rdy
);

    stage_t pipe [NUM_STAGES+1];

    // Entry point: fresh operands with no carry and an empty partial sum.
    assign pipe[0].valid = valid;
    assign pipe[0].carry = 1'b0;
    assign pipe[0].a     = a;
    assign pipe[0].b     = b;
    assign pipe[0].sum   = '0;

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        adder_64_stage #(
            .SLICE     (SLICE_W),
            .STAGE_IDX (i)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .stage_in  (pipe[i]),
            .stage_out (pipe[i+1])
        );
    end

    assign sum = pipe[NUM_STAGES].sum;
    assign rdy = pipe[NUM_STAGES].valid;

    // The final carry (modulo wrap) and the spent operands leave the pipe here.
    logic unused_tail;
    assign unused_tail = ^{pipe[NUM_STAGES].carry, pipe[NUM_STAGES].a, pipe[NUM_STAGES].b};

endmodule : adder_64

// File: tb/tb_adder_64.sv
// Self-checking bench for adder_64: directed corner cases plus random streams,
// compared against a queue-based model of "a+b appears 3 enabled edges later".
module tb_adder_64;

    logic        clk;
    logic        rst;
    logic        en;
    logic        valid;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] sum;
    logic        rdy;

    int errors;
    int checks;

    typedef struct packed {
        logic        v;
        logic [63:0] s;
    } entry_t;

    entry_t      inflight[$];
    logic [63:0] exp_sum;
    logic        exp_rdy;

    adder_64 dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .valid (valid),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .rdy   (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        inflight.delete();
        exp_sum = '0;
        exp_rdy = 1'b0;
    endtask

    // One enabled edge: the op pushed 3 edges ago is what the outputs now show.
    task automatic modelStep(input logic v, input logic [63:0] x, input logic [63:0] y);
        entry_t e;
        inflight.push_back('{v: v, s: x + y});
        if (inflight.size() > 3) begin
            e = inflight.pop_front();
            exp_rdy = e.v;
            if (e.v) exp_sum = e.s;
        end
    endtask

    // Drive one cycle of inputs (called at a negedge), clock it, check at the next negedge.
    task automatic applyStimulus(input logic e, input logic v, input logic [63:0] x, input logic [63:0] y);
        en = e; valid = v; a = x; b = y;
        @(posedge clk);
        if (rst && e) modelStep(v, x, y);
        @(negedge clk);
        checkOutput("rdy", {63'b0, rdy}, {63'b0, exp_rdy});
        checkOutput("sum", sum, exp_sum);
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        modelReset();
        rst = 1'b0; en = 1'b1; valid = 1'b0; a = '0; b = '0;

        // Reset held with random traffic: outputs must stay cleared.
        @(negedge clk);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)), rand64(), rand64());
        rst = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, rand64(), rand64());

        // Single op 3 + 4, then idle so sum must hold 7 with rdy low.
        applyStimulus(1'b1, 1'b1, 64'd3, 64'd4);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, '0, '0);

        // Carry ripple across slice boundaries and wrap-around at the MSB.
        applyStimulus(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        applyStimulus(1'b1, 1'b1, 64'h0000_0000_0000_FFFF, 64'd1);
        applyStimulus(1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        applyStimulus(1'b1, 1'b1, 64'h0000_FFFF_FFFF_FFFF, 64'd1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0, '0);

        // Streaming: every cycle, then every other cycle.
        for (int i = 0; i < 250; i++) applyStimulus(1'b1, 1'b1, rand64(), rand64());
        for (int i = 0; i < 250; i++) applyStimulus(1'b1, 1'(i % 2 == 0), rand64(), rand64());
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0, '0);

        // Stall with 3 ops in flight; inputs offered during the stall must be ignored.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, rand64(), rand64());
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, rand64(), rand64());
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, rand64(), rand64());

        // Stall while a rdy pulse is showing: it must stay high until re-enabled.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, rand64(), rand64());
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, rand64(), rand64());
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, '0, '0);

        // Reset mid-flight: outputs clear asynchronously, nothing stale after release.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, rand64(), rand64());
        #2 rst = 1'b0;
        #1;
        modelReset();
        checkOutput("async_rst_rdy", {63'b0, rdy}, 64'd0);
        checkOutput("async_rst_sum", sum, 64'd0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, rand64(), rand64());
        rst = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, '0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_adder_64
